// File: rtl/vcell_wrapper_pkg.sv
// Shared MD constants and the packed velocity/position record layout.
package vcell_wrapper_pkg;

    localparam int FLOAT_STRUCT_WIDTH = 96;
    localparam int PARTICLE_ID_WIDTH  = 7;

    // z in the top word, x in the bottom word
    typedef struct packed {
        logic [31:0] z;
        logic [31:0] y;
        logic [31:0] x;
    } float_data_t;

endpackage

// File: rtl/vcell_vel_ram.sv
// Simple dual-port RAM, synchronous read-first output, no reset (block-RAM friendly).
module vcell_vel_ram #(
    parameter int DATA_W = 96,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra,
    output logic [DATA_W-1:0] rd
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Reading mem in the same block as the write yields old data on a collision
    always_ff @(posedge clk) begin
        if (we)
            mem[wa] <= wd;
        rd <= mem[ra];
    end

endmodule

// File: rtl/vcell_wrapper.sv
// Per-cell velocity store: RAM plus a valid bitmap that masks unwritten slots to zero.
module vcell_wrapper
    import vcell_wrapper_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic [FLOAT_STRUCT_WIDTH-1:0] vel_in_0,
    input  logic [PARTICLE_ID_WIDTH-1:0]  wr_addr_0,
    input  logic                          wr_en_0,
    input  logic [PARTICLE_ID_WIDTH-1:0]  rd_addr_0,
    output logic [FLOAT_STRUCT_WIDTH-1:0] vel_out_0
);

    localparam int DEPTH  = 2 ** PARTICLE_ID_WIDTH;
    localparam int STAGES = 1;

    logic [DEPTH-1:0]              valid;
    logic [STAGES:0]               vld_pipe;
    logic [FLOAT_STRUCT_WIDTH-1:0] ram_q;
    logic                          ram_we;

    assign ram_we = wr_en_0 & ~rst;

    vcell_vel_ram #(
        .DATA_W (FLOAT_STRUCT_WIDTH),
        .ADDR_W (PARTICLE_ID_WIDTH)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .wa  (wr_addr_0),
        .wd  (vel_in_0),
        .ra  (rd_addr_0),
        .rd  (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (wr_en_0)
            valid[wr_addr_0] <= 1'b1;
    end

    // Stage 0 samples the pre-write valid bit, giving read-first semantics for the mask too
    assign vld_pipe[0] = valid[rd_addr_0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // The reset-cleared valid stage also forces zero over stale, unreset RAM output
    assign vel_out_0 = vld_pipe[STAGES] ? ram_q : '0;

endmodule

// File: tb/tb_vcell_wrapper.sv
// Directed-vector bench for vcell_wrapper: table of per-cycle vectors plus sweep and async-reset sequences.
module tb_vcell_wrapper;
    import vcell_wrapper_pkg::*;

    typedef struct {
        logic                          rst;
        logic                          wr_en;
        logic [PARTICLE_ID_WIDTH-1:0]  wr_addr;
        logic [FLOAT_STRUCT_WIDTH-1:0] vel_in;
        logic [PARTICLE_ID_WIDTH-1:0]  rd_addr;
        logic [FLOAT_STRUCT_WIDTH-1:0] exp_out;
        string                         name;
    } vec_t;

    logic                          clk;
    logic                          rst;
    logic [FLOAT_STRUCT_WIDTH-1:0] vel_in_0;
    logic [PARTICLE_ID_WIDTH-1:0]  wr_addr_0;
    logic                          wr_en_0;
    logic [PARTICLE_ID_WIDTH-1:0]  rd_addr_0;
    logic [FLOAT_STRUCT_WIDTH-1:0] vel_out_0;

    int n_vec;
    int n_err;
    vec_t tbl[$];

    vcell_wrapper dut (
        .clk       (clk),
        .rst       (rst),
        .vel_in_0  (vel_in_0),
        .wr_addr_0 (wr_addr_0),
        .wr_en_0   (wr_en_0),
        .rd_addr_0 (rd_addr_0),
        .vel_out_0 (vel_out_0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic we, input int wa, input logic [95:0] wd,
                       input int ra, input logic [95:0] exp_v, input string nm);
        vec_t v;
        v.rst = r; v.wr_en = we;
        v.wr_addr = wa[PARTICLE_ID_WIDTH-1:0];
        v.vel_in = wd;
        v.rd_addr = ra[PARTICLE_ID_WIDTH-1:0];
        v.exp_out = exp_v; v.name = nm;
        tbl.push_back(v);
    endtask

    task automatic check(input string nm, input logic [95:0] exp_v);
        n_vec++;
        if (vel_out_0 !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, vel_out_0, exp_v);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [6:0] wa,
                         input logic [95:0] wd, input logic [6:0] ra);
        rst = r; wr_en_0 = we; wr_addr_0 = wa; vel_in_0 = wd; rd_addr_0 = ra;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive(1'b1, 1'b0, '0, '0, '0);

        for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, "reset_hold");
        add(0, 0, 0, 0,     0, 0, "idle_after_reset");
        add(0, 1, 1, 96'h1, 0, 0, "write_addr1");
        for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0, "idle_pre_read");
        add(0, 0, 0, 0, 1, 96'h1, "read_addr1");
        add(0, 0, 0, 0, 1, 96'h1, "read_addr1_held");
        add(0, 1, 5, 96'hDEAD, 6, 0, "write5_read6");
        add(0, 0, 0, 0, 6, 0,        "unwritten_addr6");
        add(0, 0, 0, 0, 5, 96'hDEAD, "read_addr5");
        add(0, 1, 3, 96'hA, 3, 0,    "collide_invalid");
        add(0, 1, 3, 96'hB, 3, 96'hA, "collide_read_first");
        add(0, 0, 0, 0, 3, 96'hB,     "after_collide");
        add(1, 1, 9, 96'h55, 3, 0,    "write_during_rst");
        add(0, 0, 0, 0, 9, 0,         "rst_write_ignored");
        add(0, 0, 0, 0, 3, 0,         "rst_invalidated");

        // Table vectors: drive, take an edge, sample 1 time unit later
        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].wr_en, tbl[i].wr_addr, tbl[i].vel_in, tbl[i].rd_addr);
            @(posedge clk); #1;
            check(tbl[i].name, tbl[i].exp_out);
        end

        // Sweep: back-to-back writes 0..127, then back-to-back reads
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b1, 7'(i), 96'(i + 100), 7'd0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 128; i++) begin
            drive(1'b0, 1'b0, '0, '0, 7'(i));
            @(posedge clk); #1;
            check($sformatf("sweep_addr%0d", i), 96'(i + 100));
        end

        // Async reset mid-operation
        drive(1'b0, 1'b1, 7'd2, 96'h7, 7'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0, 7'd2);
        @(posedge clk); #1;
        check("pre_async_rst_addr2", 96'h7);
        #2 rst = 1'b1;
        #1 check("async_rst_immediate", '0);
        @(posedge clk); #1;
        check("async_rst_held", '0);
        rst = 1'b0;
        #1 check("after_release_no_edge", '0);
        @(posedge clk); #1;
        check("after_release_addr2", '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
